// File: rtl/mvm_result_fifo.sv
// mvm_result_fifo: circular result FIFO between the MVM MAC output handshake and the consumer.
// Define MVM_RESULT_LAST_EN to add a pop row counter and the out_last vector-end tag.
module mvm_result_fifo #(
    parameter int DATA_LENGTH       = 14,
    parameter int MATRIX_ROW_LENGTH = 8,
    parameter int DEPTH             = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_LENGTH-1:0]   in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_LENGTH-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef MVM_RESULT_LAST_EN
    output logic                     out_last,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [AW-1:0] STEP = AW'(1);

    logic [DATA_LENGTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic push;
    logic pop;

    always_comb begin
        in_ready  = count != FULL;
        out_valid = count != '0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + STEP : wr_ptr;
            rd_ptr <= pop ? rd_ptr + STEP : rd_ptr;
            count  <= (push && !pop) ? count + ONE : (pop && !push) ? count - ONE : count;
        end
    end

`ifdef MVM_RESULT_LAST_EN
    localparam int RW = $clog2(MATRIX_ROW_LENGTH) + 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_ROW_LENGTH - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    logic [RW-1:0] row;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) row <= '0;
        else if (pop) row <= (row == ROW_LAST) ? '0 : row + ROW_ONE;
    end

    assign out_last = out_valid && (row == ROW_LAST);
`endif
endmodule

// File: doc/mvm_result_fifo.md
# mvm_result_fifo

Output buffering stage placed directly downstream of the matrix-vector MAC datapath/control pair. Accepts each finished dot-product result (post-ReLU, signed, DATA_LENGTH bits) over the MAC's output_valid/output_ready handshake. Holds results in a small circular FIFO and re-presents them to the consumer over a valid/ready handshake. This decouples the MAC from consumer stalls, so the accumulator is no longer frozen by a single-cycle output_ready drop.

## Interface
- DATA_LENGTH, 14, width of each signed result word
- MATRIX_ROW_LENGTH, 8, results per output vector (row count of the matrix); used for last-word tagging
- DEPTH, 4, FIFO entries; power of two, >= 2
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately, deassertion is synchronous to clk
- in_data  input  DATA_LENGTH  signed result from MAC (connects to output_data)
- in_valid  input  1  MAC result valid (connects to output_valid)
- in_ready  output  1  FIFO can accept (connects to MAC output_ready)
- out_data  output  DATA_LENGTH  signed head-of-FIFO word
- out_valid  output  1  head word valid
- out_ready  input  1  consumer accepts head word
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- out_last  output  1  head word is final element of a vector (present only with MVM_RESULT_LAST_EN)

## Operation
- Storage: DEPTH x DATA_LENGTH register array; wr_ptr, rd_ptr of $clog2(DEPTH) bits each, wrapping naturally from DEPTH-1 to 0; occupancy counter count.
- push = in_valid && in_ready; writes in_data to mem[wr_ptr], wr_ptr+1.
- pop = out_valid && out_ready; rd_ptr+1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- in_ready = (count != DEPTH), combinational from registered count only (no path from in_valid or out_ready).
- out_valid = (count != 0); out_data = mem[rd_ptr] (combinational read of registered state).
- Full: in_ready=0; in_data ignored even if in_valid=1; a simultaneous pop does not free a slot in the same cycle (in_ready rises the cycle after).
- Empty: out_valid=0; out_data value is don't-care; no flow-through, so a push into an empty FIFO is not visible until the next cycle.
- Push and pop in the same cycle with 0<count<DEPTH: both performed, count unchanged.
- Data passes unmodified: no saturation, sign change or ReLU here.
- Reset (asynchronous, any time, including mid-vector): wr_ptr=rd_ptr=0, count=0, row counter=0; buffered words are discarded, and array contents need not be cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, out_last=0, out_data don't-care.
- Latency: word pushed at edge k gives out_valid=1 with that word on out_data from edge k onward (visible in cycle k+1).
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- Ordering: strict FIFO order; no word lost or duplicated under any in_valid/out_ready pattern.
- Outputs are stable while out_valid=1 and out_ready=0.

## Configuration
- MVM_RESULT_LAST_EN defined: a row counter of $clog2(MATRIX_ROW_LENGTH)+1 bits counts pops and wraps to 0 after MATRIX_ROW_LENGTH-1. out_last = out_valid && (row counter == MATRIX_ROW_LENGTH-1). Reset clears the counter.
- MVM_RESULT_LAST_EN undefined: no row counter and no out_last port. All other behaviour is identical.

## Test plan
- Reset then idle: in_ready=1, out_valid=0, count=0. Assert reset (0) mid-cycle while count=3: all three clear immediately, without waiting for a clock edge.
- Push 5, -7, 100, 0 with out_ready=0 (DEPTH=4): count reaches 4 and in_ready=0. Push 33 while full: ignored. Then out_ready=1: pops are 5, -7, 100, 0 in order, then out_valid=0.
- Full FIFO with in_valid=1 and out_ready=1 together: one pop in that cycle, count 4->3, in_ready=1 the next cycle, then push resumes.
- Streaming with in_valid=1 and out_ready=1 every cycle for 16 values 1..16: after 1-cycle latency, output is 1..16 one per cycle, count stays at 1.
- Random in_valid/out_ready (50%) over 1000 words including -8192 and 8191: the output sequence matches a scoreboard exactly, and count never exceeds 4.
- With MVM_RESULT_LAST_EN, MATRIX_ROW_LENGTH=8, push 16 words: out_last=1 only on the 8th and 16th pops. Reset after the 3rd pop, then push 8 words: out_last=1 on the 8th pop after reset.
